// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// The MEM_ARB_TIMEOUT_EN macro (used by mem_port_arbiter) gives TIMEOUT_READ_VAL its meaning.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    typedef logic port_id_t;

    localparam logic [31:0] TIMEOUT_READ_VAL = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arb_rr_picker.sv
// Combinational round-robin choice between two requesters.
// On a tie the port that did not win last time is chosen.
module mem_arb_rr_picker
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_id_t   last_grant,
    output logic       grant_valid,
    output port_id_t   grant_id
);

    always_comb begin
        // NOTE: every output gets a value before any branch, so no latch can be inferred.
        grant_valid = |req;
        grant_id    = req[1];
        if (&req) begin
            grant_id = ~last_grant;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises two level-held requesters onto one single-command memory port.
// Optional WAIT watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic              p0_read_en,
    input  logic              p0_write_en,
    input  logic [DATA_W-1:0] p0_write_val,
    output logic [DATA_W-1:0] p0_read_val,
    output logic              p0_response,
    output logic              p0_error,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic              p1_read_en,
    input  logic              p1_write_en,
    input  logic [DATA_W-1:0] p1_write_val,
    output logic [DATA_W-1:0] p1_read_val,
    output logic              p1_response,
    output logic              p1_error,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [DATA_W-1:0] mem_write_val,
    input  logic [DATA_W-1:0] mem_read_val,
    input  logic              mem_response,
    output logic              busy,
    output port_id_t          grant_id
);

    state_t   state;
    op_t      op;
    port_id_t last_grant;

    logic [1:0]        req;
    logic              pick_valid;
    port_id_t          pick_id;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_write_val;
    logic              sel_write;

    assign req           = {p1_read_en | p1_write_en, p0_read_en | p0_write_en};
    assign sel_addr      = pick_id ? p1_addr      : p0_addr;
    assign sel_write_val = pick_id ? p1_write_val : p0_write_val;
    assign sel_write     = pick_id ? p1_write_en  : p0_write_en;
    assign busy          = (state != IDLE);

    mem_arb_rr_picker u_picker (
        .req         (req),
        .last_grant  (last_grant),
        .grant_valid (pick_valid),
        .grant_id    (pick_id)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] wait_cnt;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            op            <= OP_READ;
            last_grant    <= 1'b1;
            grant_id      <= 1'b0;
            mem_addr      <= '0;
            mem_write_val <= '0;
            mem_read_en   <= 1'b0;
            mem_write_en  <= 1'b0;
            p0_read_val   <= '0;
            p1_read_val   <= '0;
            p0_response   <= 1'b0;
            p1_response   <= 1'b0;
            p0_error      <= 1'b0;
            p1_error      <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_cnt      <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout; pulse outputs default low and are raised below.
            mem_read_en  <= 1'b0;
            mem_write_en <= 1'b0;
            p0_response  <= 1'b0;
            p1_response  <= 1'b0;
            p0_error     <= 1'b0;
            p1_error     <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_id      <= pick_id;
                        last_grant    <= pick_id;
                        mem_addr      <= sel_addr;
                        mem_write_val <= sel_write_val;
                        op            <= sel_write ? OP_WRITE : OP_READ;
                        mem_write_en  <= sel_write;
                        mem_read_en   <= ~sel_write;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                WAIT: begin
                    if (mem_response) begin
                        if (op == OP_READ) begin
                            if (grant_id) p1_read_val <= mem_read_val;
                            else          p0_read_val <= mem_read_val;
                        end
                        p0_response <= ~grant_id;
                        p1_response <= grant_id;
                        state       <= DONE;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    // A response arriving on the expiry cycle takes priority over the timeout.
                    else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        if (grant_id) p1_read_val <= DATA_W'(TIMEOUT_READ_VAL);
                        else          p0_read_val <= DATA_W'(TIMEOUT_READ_VAL);
                        p0_response <= ~grant_id;
                        p1_response <= grant_id;
                        p0_error    <= ~grant_id;
                        p1_error    <= grant_id;
                        state       <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model of the arbitration and completion rules.
module tb_mem_port_arbiter;

    localparam int TO = 8;

    logic        clk;
    logic        reset;
    logic [31:0] p0_addr, p1_addr, p0_write_val, p1_write_val;
    logic        p0_read_en, p0_write_en, p1_read_en, p1_write_en;
    logic [31:0] p0_read_val, p1_read_val;
    logic        p0_response, p1_response, p0_error, p1_error;
    logic [31:0] mem_addr, mem_write_val, mem_read_val;
    logic        mem_read_en, mem_write_en, mem_response;
    logic        busy, grant_id;

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level model state
    logic [31:0] pend_addr [2];
    logic [31:0] pend_wv   [2];
    bit          pend_rd   [2];
    bit          pend_wr   [2];
    logic [31:0] exp_rv    [2];
    bit          m_last;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .p0_addr       (p0_addr),
        .p0_read_en    (p0_read_en),
        .p0_write_en   (p0_write_en),
        .p0_write_val  (p0_write_val),
        .p0_read_val   (p0_read_val),
        .p0_response   (p0_response),
        .p0_error      (p0_error),
        .p1_addr       (p1_addr),
        .p1_read_en    (p1_read_en),
        .p1_write_en   (p1_write_en),
        .p1_write_val  (p1_write_val),
        .p1_read_val   (p1_read_val),
        .p1_response   (p1_response),
        .p1_error      (p1_error),
        .mem_addr      (mem_addr),
        .mem_read_en   (mem_read_en),
        .mem_write_en  (mem_write_en),
        .mem_write_val (mem_write_val),
        .mem_read_val  (mem_read_val),
        .mem_response  (mem_response),
        .busy          (busy),
        .grant_id      (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit pending(input int p);
        return pend_rd[p] | pend_wr[p];
    endfunction

    task automatic drive_ports();
        p0_addr = pend_addr[0]; p0_write_val = pend_wv[0];
        p0_read_en = pend_rd[0]; p0_write_en = pend_wr[0];
        p1_addr = pend_addr[1]; p1_write_val = pend_wv[1];
        p1_read_en = pend_rd[1]; p1_write_en = pend_wr[1];
    endtask

    task automatic set_req(input int p, input bit rd, input bit wr,
                           input logic [31:0] a, input logic [31:0] wv);
        pend_rd[p] = rd; pend_wr[p] = wr; pend_addr[p] = a; pend_wv[p] = wv;
    endtask

    task automatic new_req(input int p);
        int kind;
        kind = $urandom_range(0, 2);
        set_req(p, kind != 1, kind != 0, $urandom, $urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_grant"}, grant_id, 0);
        check({tag, "_cmd"}, {mem_read_en, mem_write_en}, 0);
        check({tag, "_maddr"}, mem_addr, 0);
        check({tag, "_mwval"}, mem_write_val, 0);
        check({tag, "_resp"}, {p0_response, p1_response, p0_error, p1_error}, 0);
        check({tag, "_rv0"}, p0_read_val, 0);
        check({tag, "_rv1"}, p1_read_val, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int p = 0; p < 2; p++) set_req(p, 0, 0, '0, '0);
        drive_ports();
        mem_response = 1'b0;
        mem_read_val = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        m_last = 1'b1;
        exp_rv[0] = '0;
        exp_rv[1] = '0;
        @(negedge clk);
    endtask

    // Called at a negedge with the DUT in IDLE and requests already set in the model.
    task automatic txn(input int lat, input logic [31:0] rdata, input bit stray, output bit g_obs);
        bit          g, w;
        logic [31:0] a, wv;
        g  = (pending(0) && pending(1)) ? ~m_last : pending(1);
        w  = pend_wr[g];
        a  = pend_addr[g];
        wv = pend_wv[g];
        drive_ports();
        mem_response = stray;
        mem_read_val = $urandom;
        @(negedge clk);
        g_obs = grant_id;
        check("issue_grant", grant_id, g);
        check("issue_rd", mem_read_en, !w);
        check("issue_wr", mem_write_en, w);
        check("issue_addr", mem_addr, a);
        if (w) check("issue_wval", mem_write_val, wv);
        check("issue_busy", busy, 1);
        mem_response = stray;
        @(negedge clk);
        mem_response = 1'b0;
        for (int i = 0; i < lat; i++) begin
            check("wait_cmd", {mem_read_en, mem_write_en}, 0);
            check("wait_resp", {p1_response, p0_response}, 0);
            @(negedge clk);
        end
        check("wait_cmd", {mem_read_en, mem_write_en}, 0);
        mem_response = 1'b1;
        mem_read_val = rdata;
        @(negedge clk);
        mem_response = stray;
        mem_read_val = $urandom;
        check("done_resp", {p1_response, p0_response}, g ? 2'b10 : 2'b01);
        check("done_err", {p1_error, p0_error}, 0);
        if (!w) exp_rv[g] = rdata;
        check("done_rv0", p0_read_val, exp_rv[0]);
        check("done_rv1", p1_read_val, exp_rv[1]);
        pend_rd[g] = 0;
        pend_wr[g] = 0;
        drive_ports();
        m_last = g;
        @(negedge clk);
        mem_response = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_resp", {p1_response, p0_response}, 0);
    endtask

    initial begin
        bit   g;
        bit   seq [6];
        reset = 1'b1;
        for (int p = 0; p < 2; p++) set_req(p, 0, 0, '0, '0);
        exp_rv[0] = '0;
        exp_rv[1] = '0;
        drive_ports();
        mem_response = 1'b0;
        mem_read_val = '0;
        m_last = 1'b1;
        do_reset();

        // Port 0 read only, response two cycles after the command
        set_req(0, 1, 0, 32'h100, '0);
        txn(1, 32'h1234_5678, 0, g);

        // Simultaneous requests straight after reset: port 0 first, then port 1 write
        do_reset();
        set_req(0, 1, 0, 32'h10, '0);
        set_req(1, 0, 1, 32'h20, 32'hCAFE_CAFE);
        txn(0, 32'hA5A5_0001, 0, g);
        check("tie_first", g, 0);
        txn(0, 32'hA5A5_0002, 0, g);
        check("tie_second", g, 1);

        // Both ports held requesting: strict alternation
        for (int k = 0; k < 6; k++) begin
            for (int p = 0; p < 2; p++) if (!pending(p)) new_req(p);
            txn($urandom_range(0, 3), $urandom, 0, g);
            seq[k] = g;
        end
        for (int k = 0; k < 6; k++) check("alt_seq", seq[k], k % 2);

        // Port 1 read and write together: write wins
        set_req(1, 1, 1, 32'h40, 32'h1);
        txn(0, 32'hBAD0_BAD0, 0, g);

        // Randomized traffic with stray responses outside WAIT
        for (int k = 0; k < 150; k++) begin
            for (int p = 0; p < 2; p++) if (!pending(p) && $urandom_range(0, 1) == 1) new_req(p);
            if (!pending(0) && !pending(1)) new_req($urandom_range(0, 1));
            txn($urandom_range(0, 4), $urandom, 1'($urandom_range(0, 1)), g);
        end
        for (int p = 0; p < 2; p++) set_req(p, 0, 0, '0, '0);
        drive_ports();
        @(negedge clk);

        // Reset during WAIT, then a late response
        set_req(0, 1, 0, 32'h80, '0);
        drive_ports();
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_busy", busy, 1);
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        set_req(0, 0, 0, '0, '0);
        drive_ports();
        @(negedge clk);
        reset = 1'b0;
        m_last = 1'b1;
        exp_rv[0] = '0;
        exp_rv[1] = '0;
        mem_response = 1'b1;
        mem_read_val = 32'h5555_AAAA;
        @(negedge clk);
        mem_response = 1'b0;
        check_reset_outputs("late_resp");
        @(negedge clk);
        check_reset_outputs("late_resp2");

        // WAIT with no memory response
        set_req(1, 1, 0, 32'h300, '0);
        drive_ports();
        @(negedge clk);
        check("to_issue_rd", mem_read_en, 1);
`ifdef MEM_ARB_TIMEOUT_EN
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            check("to_wait_resp", {p1_response, p0_response}, 0);
        end
        @(negedge clk);
        check("to_resp", {p1_response, p0_response}, 2'b10);
        check("to_err", {p1_error, p0_error}, 2'b10);
        check("to_rv", p1_read_val, 32'hDEAD_BEEF);
        set_req(1, 0, 0, '0, '0);
        drive_ports();
        @(negedge clk);
        check("to_idle", busy, 0);
`else
        repeat (100) @(negedge clk);
        check("stuck_busy", busy, 1);
        check("stuck_resp", {p1_response, p0_response, p1_error, p0_error}, 0);
        do_reset();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port arbiter that shares the single-request MemoryController port between the CPU instruction-fetch path (port 0) and the load/store path (port 1). Accepts level-held read/write requests from each requester and serialises them round-robin. Issues exactly one one-cycle command to the controller at a time and routes the response and read data back to the granted requester. Sits between the core's memory stage and the MemoryController `mem_*` interface.

## Interface
- ADDR_W, 32, request/memory address width
- DATA_W, 32, read/write data width
- TIMEOUT_CYCLES, 1024, WAIT-state cycle limit (used only with MEM_ARB_TIMEOUT_EN)
- clk  in  1  single clock for all logic
- reset  in  1  asynchronous, active-high reset; one clock, reset is asynchronous and active-high
- pN_addr  in  ADDR_W  port N address (N = 0, 1)
- pN_read_en  in  1  port N read request, held until pN_response
- pN_write_en  in  1  port N write request, held until pN_response
- pN_write_val  in  DATA_W  port N write data
- pN_read_val  out  DATA_W  port N read data, valid while pN_response = 1
- pN_response  out  1  one-cycle completion pulse to port N
- pN_error  out  1  one-cycle timeout flag, coincident with pN_response
- mem_addr  out  ADDR_W  address to MemoryController
- mem_read_en  out  1  one-cycle read command pulse
- mem_write_en  out  1  one-cycle write command pulse
- mem_write_val  out  DATA_W  write data to MemoryController
- mem_read_val  in  DATA_W  read data, valid with mem_response
- mem_response  in  1  one-cycle completion pulse from MemoryController
- busy  out  1  high in any state other than IDLE
- grant_id  out  1  port currently owning the transaction

## Operation
- States: IDLE, ISSUE, WAIT, DONE. Registered outputs throughout.
- IDLE:
  - Port N is requesting when pN_read_en | pN_write_en.
  - If only one port requests, grant it.
  - If both request, grant the port != last_grant.
  - On grant: latch addr, write_val and op (write if pN_write_en, else read; write wins if both asserted); set grant_id and last_grant; go to ISSUE.
- ISSUE: mem_read_en or mem_write_en = 1 for exactly this cycle; mem_addr/mem_write_val hold latched values; go to WAIT.
- WAIT:
  - On mem_response: capture mem_read_val into pG_read_val (unchanged on writes); go to DONE.
  - mem_response in any state other than WAIT is ignored.
- DONE: pG_response = 1 for exactly this cycle; go to IDLE.
  - Requesters drop their level during DONE, so the following IDLE cycle does not re-grant the completed request.
- Request inputs sampled in any state other than IDLE are ignored.
- Reset values:
  - state = IDLE, last_grant = 1 (port 0 wins the first tie).
  - grant_id = 0, busy = 0.
  - All mem_*_en = 0, mem_addr = 0, mem_write_val = 0.
  - pN_response = 0, pN_error = 0, pN_read_val = 0.
- Reset asserted mid-transaction: the in-flight transaction is abandoned with no response to the requester; a late mem_response after reset release is ignored (state is IDLE).

## Timing
- Request seen in IDLE at cycle 0 → command pulse in cycle 1 → earliest mem_response in cycle 2 → pN_response in cycle 3.
- Arbitration overhead: 2 cycles (IDLE + DONE) between back-to-back transactions.
- Throughput: one outstanding transaction; the next grant occurs no earlier than 1 cycle after DONE.
- Both ports continuously requesting: grants strictly alternate 0,1,0,1.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When the count reaches TIMEOUT_CYCLES-1 without mem_response: go to DONE with pG_error = 1 and pG_read_val = 32'hDEAD_BEEF.
  - mem_response in the same cycle as expiry wins, and no error is flagged.
- MEM_ARB_TIMEOUT_EN undefined: no counter; WAIT waits indefinitely; pN_error tied to 0.

## Structure
- Package mem_arb_pkg:
  - state enum (IDLE/ISSUE/WAIT/DONE)
  - op encoding (OP_READ/OP_WRITE)
  - port id type
  - TIMEOUT_READ_VAL = 32'hDEAD_BEEF
- Sub-module mem_arb_rr_picker (combinational): inputs req[1:0], last_grant; outputs grant_valid, grant_id.

## Test plan
- Port 0 read only, addr 0x100, memory returns 0x1234_5678 two cycles after the command → one mem_read_en pulse with mem_addr = 0x100; p0_read_val = 0x1234_5678 with a single p0_response pulse; port 1 sees no response.
- Both ports request in the same cycle after reset (p0 read 0x10, p1 write 0x20 = 0xCAFE_CAFE) → p0 served first, then p1 write with mem_write_val = 0xCAFE_CAFE; grant order 0,1.
- Both ports held requesting for 6 transactions → grant_id sequence 0,1,0,1,0,1; never two overlapping command pulses.
- Port 1 asserts read_en and write_en together (addr 0x40, data 0x1) → a write is issued, no read.
- Reset asserted during WAIT, then mem_response pulses after reset release → no pN_response, and all outputs at their reset values.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, no mem_response → pG_response and pG_error high in the same cycle, pG_read_val = 0xDEAD_BEEF, then back to IDLE; without the macro, still busy after 100 cycles.
